// File: rtl/lstm_quant_pkg.sv
// Shared quantization constants and the signed rounding shift used by the
// LSTM cell-state datapath.
//   Contents: default widths, zero points and log2 scales; rounding-mode
//   selectors; R() = sign-magnitude right shift with optional half-up rounding.
package lstm_quant_pkg;

    localparam int unsigned DEF_LANES                  = 4;
    localparam int unsigned DEF_DATA_W                 = 8;
    localparam int unsigned DEF_ZERO_STATE             = 128;
    localparam int unsigned DEF_OUT_ZERO_SIGMOID       = 0;
    localparam int unsigned DEF_OUT_ZERO_TANH          = 128;
    localparam int unsigned DEF_LOG2_SCALE_STATE       = 7;
    localparam int unsigned DEF_LOG2_OUT_SCALE_SIGMOID = 8;
    localparam int unsigned DEF_LOG2_OUT_SCALE_TANH    = 7;
    localparam int unsigned DEF_CNT_W                  = 16;

    localparam int unsigned ROUND_TRUNC = 0;
    localparam int unsigned ROUND_NEAR  = 1;

    localparam int unsigned ACC_W = 32;

    // Shift |x| right by k and restore the sign, so truncation is toward zero
    // and rounding is half away from zero.
    function automatic logic signed [ACC_W-1:0] R(
        input logic signed [ACC_W-1:0] x,
        input int unsigned             k,
        input logic                    near
    );
        logic [ACC_W-1:0] mag;
        logic [ACC_W-1:0] res;
        if (k == 0) begin
            return x;
        end
        mag = x[ACC_W-1] ? ACC_W'(-x) : ACC_W'(x);
        if (near) begin
            mag = mag + (ACC_W'(1) << (k - 1));
        end
        res = mag >> k;
        return x[ACC_W-1] ? -$signed(res) : $signed(res);
    endfunction

endpackage

// File: rtl/cell_state_lane.sv
// One lane of the cell-state update: c_t = f*c_(t-1) + i*g in the quantized
// domain, three register stages, all held while i_advance is low.
//   clk, rst       clock, synchronous active-high reset
//   i_advance      pipeline enable
//   i_f/i_i/i_g/i_c quantized forget, input, candidate gates and previous state
//   o_c_new        quantized new state (stage-3 register)
//   o_sat          new state was clamped (stage-3 register)
module cell_state_lane
    import lstm_quant_pkg::*;
#(
    parameter int unsigned DATA_W                 = DEF_DATA_W,
    parameter int unsigned ZERO_STATE             = DEF_ZERO_STATE,
    parameter int unsigned OUT_ZERO_SIGMOID       = DEF_OUT_ZERO_SIGMOID,
    parameter int unsigned OUT_ZERO_TANH          = DEF_OUT_ZERO_TANH,
    parameter int unsigned LOG2_SCALE_STATE       = DEF_LOG2_SCALE_STATE,
    parameter int unsigned LOG2_OUT_SCALE_SIGMOID = DEF_LOG2_OUT_SCALE_SIGMOID,
    parameter int unsigned LOG2_OUT_SCALE_TANH    = DEF_LOG2_OUT_SCALE_TANH,
    parameter int unsigned ROUND_MODE             = ROUND_TRUNC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_advance,
    input  logic [DATA_W-1:0] i_f,
    input  logic [DATA_W-1:0] i_i,
    input  logic [DATA_W-1:0] i_g,
    input  logic [DATA_W-1:0] i_c,
    output logic [DATA_W-1:0] o_c_new,
    output logic              o_sat
);

    localparam logic signed [ACC_W-1:0] ZS    = ACC_W'(ZERO_STATE);
    localparam logic signed [ACC_W-1:0] OZS   = ACC_W'(OUT_ZERO_SIGMOID);
    localparam logic signed [ACC_W-1:0] OZT   = ACC_W'(OUT_ZERO_TANH);
    localparam logic signed [ACC_W-1:0] U_MAX = ACC_W'((64'd1 << DATA_W) - 64'd1);
    localparam int unsigned             K_B   = LOG2_OUT_SCALE_SIGMOID + LOG2_OUT_SCALE_TANH;
    localparam logic                    NEAR  = (ROUND_MODE == ROUND_NEAR);

    logic signed [ACC_W-1:0] w_df, w_dc, w_di, w_dg;
    logic signed [ACC_W-1:0] w_pa, w_pb;
    logic signed [ACC_W-1:0] w_a, w_b, w_u;
    logic [DATA_W-1:0]       w_c_new;
    logic                    w_sat;

    logic signed [ACC_W-1:0] r_pa, r_pb;
    logic signed [ACC_W-1:0] r_a, r_b;
    logic [DATA_W-1:0]       r_c_new;
    logic                    r_sat;

    // S1: remove zero points and form both products
    assign w_df = $signed(ACC_W'(i_f)) - OZS;
    assign w_dc = $signed(ACC_W'(i_c)) - ZS;
    assign w_di = $signed(ACC_W'(i_i)) - OZS;
    assign w_dg = $signed(ACC_W'(i_g)) - OZT;
    assign w_pa = w_df * w_dc;
    assign w_pb = w_di * w_dg;

    // S2: rescale both terms to the state scale
    assign w_a = R(r_pa, LOG2_OUT_SCALE_SIGMOID, NEAR);
    assign w_b = R(r_pb <<< LOG2_SCALE_STATE, K_B, NEAR);

    // S3: re-apply the state zero point and clamp to the unsigned range
    always_comb begin
        w_u     = r_a + r_b + ZS;
        w_sat   = 1'b0;
        w_c_new = DATA_W'(w_u);
        if (w_u < 0) begin
            w_c_new = '0;
            w_sat   = 1'b1;
        end else if (w_u > U_MAX) begin
            w_c_new = '1;
            w_sat   = 1'b1;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pa    <= '0;
            r_pb    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c_new <= '0;
            r_sat   <= 1'b0;
        end else if (i_advance) begin
            r_pa    <= w_pa;
            r_pb    <= w_pb;
            r_a     <= w_a;
            r_b     <= w_b;
            r_c_new <= w_c_new;
            r_sat   <= w_sat;
        end
    end

    assign o_c_new = r_c_new;
    assign o_sat   = r_sat;

endmodule

// File: rtl/cell_state_update_pipe.sv
// Multi-lane, handshaked LSTM cell-state update pipeline with per-frame
// saturation counting.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready/in_last input beat handshake and frame end
//   f_q, i_q, g_q, c_prev_q   gate and previous-state lanes, lane k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready/out_last output beat handshake and frame end
//   c_new_q, sat_flags        new state lanes and their clamp flags
//   sat_cnt, sat_cnt_valid    clamped-lane total of the last frame and its update pulse
module cell_state_update_pipe
    import lstm_quant_pkg::*;
#(
    parameter int unsigned LANES                  = DEF_LANES,
    parameter int unsigned DATA_W                 = DEF_DATA_W,
    parameter int unsigned ZERO_STATE             = DEF_ZERO_STATE,
    parameter int unsigned OUT_ZERO_SIGMOID       = DEF_OUT_ZERO_SIGMOID,
    parameter int unsigned OUT_ZERO_TANH          = DEF_OUT_ZERO_TANH,
    parameter int unsigned LOG2_SCALE_STATE       = DEF_LOG2_SCALE_STATE,
    parameter int unsigned LOG2_OUT_SCALE_SIGMOID = DEF_LOG2_OUT_SCALE_SIGMOID,
    parameter int unsigned LOG2_OUT_SCALE_TANH    = DEF_LOG2_OUT_SCALE_TANH,
    parameter int unsigned ROUND_MODE             = ROUND_TRUNC,
    parameter int unsigned CNT_W                  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [LANES*DATA_W-1:0] f_q,
    input  logic [LANES*DATA_W-1:0] i_q,
    input  logic [LANES*DATA_W-1:0] g_q,
    input  logic [LANES*DATA_W-1:0] c_prev_q,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [LANES*DATA_W-1:0] c_new_q,
    output logic [LANES-1:0]        sat_flags,
    output logic [CNT_W-1:0]        sat_cnt,
    output logic                    sat_cnt_valid
);

    localparam int unsigned POP_W = $clog2(LANES + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    logic             w_advance;
    logic             w_out_hs;
    logic [POP_W-1:0] w_pop;
    logic [SUM_W-1:0] w_sum_wide;
    logic [CNT_W-1:0] w_sum;

    logic             r_v1, r_v2, r_v3;
    logic             r_l1, r_l2, r_l3;
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_sat_cnt;
    logic             r_cnt_vld;

    // The whole pipe moves together; a stalled output freezes every stage
    assign w_advance = !r_v3 || out_ready;
    assign w_out_hs  = r_v3 && out_ready;
    assign in_ready  = w_advance;

    // Per-lane datapath
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cell_state_lane #(
            .DATA_W                (DATA_W),
            .ZERO_STATE            (ZERO_STATE),
            .OUT_ZERO_SIGMOID      (OUT_ZERO_SIGMOID),
            .OUT_ZERO_TANH         (OUT_ZERO_TANH),
            .LOG2_SCALE_STATE      (LOG2_SCALE_STATE),
            .LOG2_OUT_SCALE_SIGMOID(LOG2_OUT_SCALE_SIGMOID),
            .LOG2_OUT_SCALE_TANH   (LOG2_OUT_SCALE_TANH),
            .ROUND_MODE            (ROUND_MODE)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_advance(w_advance),
            .i_f      (f_q[k*DATA_W +: DATA_W]),
            .i_i      (i_q[k*DATA_W +: DATA_W]),
            .i_g      (g_q[k*DATA_W +: DATA_W]),
            .i_c      (c_prev_q[k*DATA_W +: DATA_W]),
            .o_c_new  (c_new_q[k*DATA_W +: DATA_W]),
            .o_sat    (sat_flags[k])
        );
    end

    // Valid/last shift registers track the lane stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_l1 <= 1'b0;
            r_l2 <= 1'b0;
            r_l3 <= 1'b0;
        end else if (w_advance) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_l1 <= in_valid && in_last;
            r_l2 <= r_l1;
            r_l3 <= r_l2;
        end
    end

    // Clamped lanes in the current output beat
    always_comb begin
        w_pop = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_pop = w_pop + POP_W'(sat_flags[k]);
        end
    end

    // Running frame total, pinned at all-ones instead of wrapping
    assign w_sum_wide = {1'b0, r_acc} + SUM_W'(w_pop);
    assign w_sum      = w_sum_wide[CNT_W] ? '1 : w_sum_wide[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_sat_cnt <= '0;
            r_cnt_vld <= 1'b0;
        end else begin
            r_cnt_vld <= 1'b0;
            if (w_out_hs) begin
                if (r_l3) begin
                    r_sat_cnt <= w_sum;
                    r_cnt_vld <= 1'b1;
                    r_acc     <= '0;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign out_valid     = r_v3;
    assign out_last      = r_l3;
    assign sat_cnt       = r_sat_cnt;
    assign sat_cnt_valid = r_cnt_vld;

endmodule

// File: doc/cell_state_update_pipe.md
Name: cell_state_update_pipe

Overview:
- Pipelined, multi-lane, handshaked successor to the combinational LSTM cell-state quantizer.
- Per lane it computes c_t = f*c_(t-1) + i*g entirely in the 8-bit asymmetric-quantized domain, with selectable rounding and saturation to the state range.
- Sits between the gate activation units (sigmoid/tanh LUT outputs) and the state buffer.
- Streams one LANES-wide beat per cycle and reports per-frame saturation counts.

Parameters:
- LANES, 4, parallel elements per beat.
- DATA_W, 8, quantized data width (unsigned).
- ZERO_STATE, 128, zero point of c_(t-1) and c_t.
- OUT_ZERO_SIGMOID, 0, zero point of f and i.
- OUT_ZERO_TANH, 128, zero point of g.
- LOG2_SCALE_STATE, 7, state scale = 2^7.
- LOG2_OUT_SCALE_SIGMOID, 8, sigmoid output scale = 2^8.
- LOG2_OUT_SCALE_TANH, 7, tanh output scale = 2^7.
- ROUND_MODE, 0, 0 = truncate toward zero; 1 = round half away from zero.
- CNT_W, 16, saturation counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_last  in  1  last beat of frame
- f_q  in  LANES*DATA_W  forget gate, lane k at [k*DATA_W +: DATA_W]
- i_q  in  LANES*DATA_W  input gate
- g_q  in  LANES*DATA_W  candidate (tanh)
- c_prev_q  in  LANES*DATA_W  previous state
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream ready
- out_last  out  1  in_last delayed with its beat
- c_new_q  out  LANES*DATA_W  new state
- sat_flags  out  LANES  per-lane saturation of current output beat
- sat_cnt  out  CNT_W  saturated-lane count of last completed frame
- sat_cnt_valid  out  1  one-cycle pulse when sat_cnt updates

Behaviour:
- Reset: every output 0. Stage valids, frame accumulator, sat_cnt and sat_cnt_valid all 0. in_ready reads 1 once the pipe is empty, so it is 1 in the first cycle after rst. rst mid-frame drops all in-flight beats and the partial count.
- Pipeline: 3 stages; latency is exactly 3 cycles from accept to out_valid with no stall.
- Stall: advance = !out_valid || out_ready. All stages hold when advance=0. in_ready = advance.
- While stalled, c_new_q, sat_flags and out_last are stable. Beats are never dropped, duplicated or reordered.
- S1 (per lane, signed, 32-bit internal):
  - df = f-OZS, dc = c-ZS, di = i-OZS, dg = g-OZT (9-bit signed).
  - pA = df*dc; pB = di*dg.
- S2:
  - A = R(pA, LOG2_OSS).
  - B = R(pB << LOG2_SS, LOG2_OSS+LOG2_OST).
  - R(x,k) with mode 0 = sign(x)*(|x|>>k); mode 1 = sign(x)*((|x|+2^(k-1))>>k); R(x,0) = x.
- S3:
  - u = A+B+ZERO_STATE.
  - u<0 -> 0, sat. u>2^DATA_W-1 -> 2^DATA_W-1, sat. Otherwise u[DATA_W-1:0], no sat.
- Frame counting:
  - On each output handshake, the accumulator adds popcount(sat_flags).
  - If out_last, sat_cnt <= accumulator + popcount, sat_cnt_valid pulses for 1 cycle, and the accumulator is cleared.
  - The accumulator saturates at 2^CNT_W-1; no wrap.
- Single-beat frame (in_last on the first beat) is legal.
- in_valid low inserts bubbles, which propagate as out_valid=0.

Decomposition:
- Package lstm_quant_pkg: DATA_W, zero-point and log2-scale defaults, ROUND_TRUNC/ROUND_NEAR constants, and the function R().
- Sub-module cell_state_lane: one lane's S1–S3 datapath with an external advance enable. Instantiated LANES times under generate.
- The top level owns valid/last shift registers, handshake and the saturation counter.

Test Plan:
- Default params, mode 0, lane: f=128, c=228, i=0, g=200 -> c_new=178, no sat, out_valid exactly 3 cycles after accept.
- f=0, c=any, i=255, g=255 -> mode 0: 254, no sat; mode 1: 255, no sat. In mode 1 the term B (126.5) rounds up to 127, giving u=255, which is in range.
- f=255, c=255, i=255, g=255 -> u=380 -> 255, sat=1. f=255, c=0, i=255, g=0 -> u=-126 -> 0, sat=1.
- Stream 6 beats back-to-back with out_ready low for cycles 4–8 -> in_ready=0 while stalled, outputs held stable, all 6 emerge in order with correct out_last.
- LANES=4, 3-beat frame with 1, 0, 2 saturated lanes -> sat_cnt=3 with a one-cycle sat_cnt_valid aligned to the last output handshake. Next frame with no saturation -> sat_cnt=0.
- Assert rst mid-frame with 2 beats in flight -> next cycle out_valid=0 and sat_cnt=0. A new frame afterwards counts only its own saturations.
